// File: rtl/cpu_pkg.sv
// Shared CPU definitions: T-state encoding and bus address-source selects.
// Used by the instruction decoder and the cycle sequencer.
package cpu_pkg;

  localparam int unsigned CPU_STATE_W = 6;

  typedef enum logic [CPU_STATE_W-1:0] {
    T0_FETCH  = 6'd0,
    T1_DECODE = 6'd1,
    T2_ZPG    = 6'd2,
    T2_ZPGXY  = 6'd3,
    T2_ABS    = 6'd4,
    T2_ABSXY  = 6'd5,
    T3_FIX    = 6'd6,
    T2_XIND   = 6'd7,
    T3_PTRLO  = 6'd8,
    T4_PTRHI  = 6'd9,
    T2_INDY   = 6'd10,
    T3_PTRHI  = 6'd11,
    T4_FIX    = 6'd12,
    DATA      = 6'd13,
    T_RMW1    = 6'd14,
    T_RMW2    = 6'd15,
    T2_BRANCH = 6'd16,
    T3_BRFIX  = 6'd17,
    T2_STACK  = 6'd18,
    T3_PULL   = 6'd19,
    T2_BRK    = 6'd20,
    T3_BRK    = 6'd21,
    T4_BRK    = 6'd22,
    T5_VEC    = 6'd23,
    T6_VEC    = 6'd24,
    T2_JUMP   = 6'd25,
    T_JAM     = 6'd63
  } state_t;

  localparam logic [2:0] ADDR_PC    = 3'd0;
  localparam logic [2:0] ADDR_ZPG   = 3'd1;
  localparam logic [2:0] ADDR_EA    = 3'd2;
  localparam logic [2:0] ADDR_PTR   = 3'd3;
  localparam logic [2:0] ADDR_STACK = 3'd4;
  localparam logic [2:0] ADDR_VEC   = 3'd5;

  // States the decoder may legally hand over as the first state after T1_DECODE.
  function automatic logic is_entry_state(input state_t s);
    case (s)
      T0_FETCH, T2_ZPG, T2_ZPGXY, T2_ABS, T2_ABSXY, T2_XIND, T2_INDY,
      T2_BRANCH, T2_STACK, T2_BRK, T2_JUMP, T_JAM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_outputs.sv
// Combinational decode of the sequencer state into per-cycle datapath/bus strobes.
// Read cycles with i_rdy low suppress all stepping and latch strobes.
module seq_outputs
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_rdy,
  input  logic       i_single_byte,
  input  logic       i_store,
  input  logic       i_rmw,
  input  logic       i_zpg_mode,
  input  logic       i_hw_int,
  output logic       o_sync,
  output logic       o_pc_inc,
  output logic [2:0] o_addr_sel,
  output logic       o_we,
  output logic       o_ea_lo_ld,
  output logic       o_ea_hi_ld,
  output logic       o_idx_add,
  output logic       o_fix_hi,
  output logic       o_s_dec,
  output logic       o_s_inc,
  output logic       o_commit,
  output logic       o_jump_req,
  output logic       o_jam,
  output logic       o_stall
);

  logic       pc_inc, ea_lo_ld, ea_hi_ld, idx_add, fix_hi, s_dec, s_inc;
  logic [2:0] data_addr;

  assign data_addr = i_zpg_mode ? ADDR_ZPG : ADDR_EA;

  always_comb begin
    o_sync     = 1'b0;
    o_addr_sel = ADDR_PC;
    o_we       = 1'b0;
    o_commit   = 1'b0;
    o_jump_req = 1'b0;
    o_jam      = 1'b0;
    pc_inc     = 1'b0;
    ea_lo_ld   = 1'b0;
    ea_hi_ld   = 1'b0;
    idx_add    = 1'b0;
    fix_hi     = 1'b0;
    s_dec      = 1'b0;
    s_inc      = 1'b0;
    unique case (i_state)
      T0_FETCH: begin
        o_sync = 1'b1;
        pc_inc = 1'b1;
      end
      T1_DECODE: begin
        pc_inc   = !i_single_byte && !i_hw_int;
        ea_lo_ld = 1'b1;
        o_commit = 1'b1;
      end
      T2_ZPG: begin
        o_addr_sel = ADDR_ZPG;
        o_we       = i_store;
      end
      T2_ZPGXY: begin
        o_addr_sel = ADDR_ZPG;
        idx_add    = 1'b1;
      end
      T2_ABS: begin
        ea_hi_ld = 1'b1;
        pc_inc   = 1'b1;
      end
      T2_ABSXY: begin
        ea_hi_ld = 1'b1;
        pc_inc   = 1'b1;
        idx_add  = 1'b1;
      end
      T3_FIX, T4_FIX: begin
        o_addr_sel = ADDR_EA;
        fix_hi     = 1'b1;
      end
      T2_XIND: begin
        o_addr_sel = ADDR_ZPG;
        idx_add    = 1'b1;
      end
      T3_PTRLO, T2_INDY: begin
        o_addr_sel = ADDR_PTR;
        ea_lo_ld   = 1'b1;
      end
      T4_PTRHI: begin
        o_addr_sel = ADDR_PTR;
        ea_hi_ld   = 1'b1;
      end
      T3_PTRHI: begin
        o_addr_sel = ADDR_PTR;
        ea_hi_ld   = 1'b1;
        idx_add    = 1'b1;
      end
      DATA: begin
        o_addr_sel = data_addr;
        o_we       = i_store;
      end
      T_RMW1, T_RMW2: begin
        o_addr_sel = data_addr;
        o_we       = 1'b1;
      end
      T2_BRANCH: ;
      // High-byte fix of the program counter after a page-crossing branch.
      T3_BRFIX: fix_hi = 1'b1;
      T2_STACK: begin
        o_addr_sel = ADDR_STACK;
        o_we       = i_store;
        s_dec      = i_store;
        s_inc      = !i_store;
      end
      T3_PULL: o_addr_sel = ADDR_STACK;
      T2_BRK, T3_BRK, T4_BRK: begin
        o_addr_sel = ADDR_STACK;
        o_we       = 1'b1;
        s_dec      = 1'b1;
      end
      T5_VEC: begin
        o_addr_sel = ADDR_VEC;
        ea_lo_ld   = 1'b1;
      end
      T6_VEC: begin
        o_addr_sel = ADDR_VEC;
        ea_hi_ld   = 1'b1;
      end
      T2_JUMP: o_jump_req = 1'b1;
      default: o_jam = 1'b1;
    endcase
  end

  // Writes always complete; only reads wait on the bus.
  assign o_stall    = !o_we && !i_rdy;
  assign o_pc_inc   = pc_inc   && !o_stall;
  assign o_ea_lo_ld = ea_lo_ld && !o_stall;
  assign o_ea_hi_ld = ea_hi_ld && !o_stall;
  assign o_idx_add  = idx_add  && !o_stall;
  assign o_fix_hi   = fix_hi   && !o_stall;
  assign o_s_dec    = s_dec    && !o_stall;
  assign o_s_inc    = s_inc    && !o_stall;

endmodule

// File: rtl/cycle_sequencer.sv
// 6502 T-state sequencer: owns the cycle state and steps each opcode through its bus cycles.
// Define IRQ_EN to add the hardware-interrupt entry (i_irq, i_irq_mask, o_hw_int).
module cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned STATE_W      = 6,
  parameter int unsigned JUMP_TIMEOUT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rdy,
  input  logic [STATE_W-1:0] i_initial_state,
  input  logic               i_read,
  input  logic               i_load,
  input  logic               i_store,
  input  logic               i_rmw,
  input  logic               i_single_byte,
  input  logic               i_carry,
  input  logic               i_jump_done,
`ifdef IRQ_EN
  input  logic               i_irq,
  input  logic               i_irq_mask,
  output logic               o_hw_int,
`endif
  output logic [STATE_W-1:0] o_state,
  output logic               o_sync,
  output logic               o_pc_inc,
  output logic [2:0]         o_addr_sel,
  output logic               o_we,
  output logic               o_ea_lo_ld,
  output logic               o_ea_hi_ld,
  output logic               o_idx_add,
  output logic               o_fix_hi,
  output logic               o_s_dec,
  output logic               o_s_inc,
  output logic               o_commit,
  output logic               o_jump_req,
  output logic               o_jam
);

  localparam int unsigned CNT_W = $clog2(JUMP_TIMEOUT + 1);

  state_t             state_q, state_d, init_state;
  logic               zpg_q, zpg_d;
  logic [CNT_W-1:0]   jcnt_q, jcnt_d;
  logic               stall, irq_pend, need_fix;
  logic               unused_read_pattern;

  // Reads and loads sequence identically; only store/rmw change the path.
  assign unused_read_pattern = i_read ^ i_load;

  assign init_state = state_t'(i_initial_state);
  assign need_fix   = i_carry || i_store || i_rmw;
  assign o_state    = STATE_W'(state_q);

`ifdef IRQ_EN
  logic irq_q, irq_d;

  assign irq_pend = irq_q;
  assign o_hw_int = irq_q && (state_q inside {T2_BRK, T3_BRK, T4_BRK, T5_VEC, T6_VEC});

  always_comb begin
    irq_d = irq_q;
    if (state_q == T0_FETCH && i_irq && !i_irq_mask) begin
      irq_d = 1'b1;
    end else if (state_q == T6_VEC && !stall) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end
`else
  assign irq_pend = 1'b0;
`endif

  seq_outputs u_seq_outputs (
    .i_state       (state_q),
    .i_rdy         (i_rdy),
    .i_single_byte (i_single_byte),
    .i_store       (i_store),
    .i_rmw         (i_rmw),
    .i_zpg_mode    (zpg_q),
    .i_hw_int      (irq_pend),
    .o_sync        (o_sync),
    .o_pc_inc      (o_pc_inc),
    .o_addr_sel    (o_addr_sel),
    .o_we          (o_we),
    .o_ea_lo_ld    (o_ea_lo_ld),
    .o_ea_hi_ld    (o_ea_hi_ld),
    .o_idx_add     (o_idx_add),
    .o_fix_hi      (o_fix_hi),
    .o_s_dec       (o_s_dec),
    .o_s_inc       (o_s_inc),
    .o_commit      (o_commit),
    .o_jump_req    (o_jump_req),
    .o_jam         (o_jam),
    .o_stall       (stall)
  );

  always_comb begin
    state_d = state_q;
    zpg_d   = zpg_q;
    jcnt_d  = '0;
    if (stall) begin
      jcnt_d = jcnt_q;
    end else begin
      unique case (state_q)
        T0_FETCH:  state_d = T1_DECODE;
        T1_DECODE: begin
          // Zero-page modes keep using the ZPG source through the data/RMW cycles.
          zpg_d = (init_state == T2_ZPG) || (init_state == T2_ZPGXY);
          if (irq_pend) begin
            state_d = T2_BRK;
          end else if (is_entry_state(init_state)) begin
            state_d = init_state;
          end else begin
            state_d = T_JAM;
          end
        end
        T2_ZPG, DATA: state_d = i_rmw ? T_RMW1 : T0_FETCH;
        T2_ZPGXY, T2_ABS, T3_FIX, T4_PTRHI, T4_FIX: state_d = DATA;
        T2_ABSXY:  state_d = need_fix ? T3_FIX : DATA;
        T2_XIND:   state_d = T3_PTRLO;
        T3_PTRLO:  state_d = T4_PTRHI;
        T2_INDY:   state_d = T3_PTRHI;
        T3_PTRHI:  state_d = need_fix ? T4_FIX : DATA;
        T_RMW1:    state_d = T_RMW2;
        T2_BRANCH: state_d = i_carry ? T3_BRFIX : T0_FETCH;
        T2_STACK:  state_d = i_store ? T0_FETCH : T3_PULL;
        T2_BRK:    state_d = T3_BRK;
        T3_BRK:    state_d = T4_BRK;
        T4_BRK:    state_d = T5_VEC;
        T5_VEC:    state_d = T6_VEC;
        T_RMW2, T3_BRFIX, T3_PULL, T6_VEC: state_d = T0_FETCH;
        T2_JUMP: begin
          if (i_jump_done) begin
            state_d = T0_FETCH;
          end else if (jcnt_q == CNT_W'(JUMP_TIMEOUT - 1)) begin
            state_d = T_JAM;
          end else begin
            jcnt_d = jcnt_q + CNT_W'(1);
          end
        end
        default:   state_d = T_JAM;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= T0_FETCH;
      zpg_q   <= 1'b0;
      jcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      zpg_q   <= zpg_d;
      jcnt_q  <= jcnt_d;
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: directed per-cycle vectors, checked by a negedge monitor.
module tb_cycle_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b1;
  logic [5:0] init = 6'd0;
  logic       rd = 1'b1, ld = 1'b0, st = 1'b0, rmw = 1'b0;
  logic       single = 1'b0, carry = 1'b0, jdone = 1'b0;

  logic [5:0] o_state;
  logic [2:0] o_addr_sel;
  logic o_sync, o_pc_inc, o_we, o_ea_lo_ld, o_ea_hi_ld, o_idx_add, o_fix_hi;
  logic o_s_dec, o_s_inc, o_commit, o_jump_req, o_jam;
`ifdef IRQ_EN
  logic o_hw_int;
`endif

  cycle_sequencer #(
    .STATE_W      (6),
    .JUMP_TIMEOUT (8)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rdy           (rdy),
    .i_initial_state (init),
    .i_read          (rd),
    .i_load          (ld),
    .i_store         (st),
    .i_rmw           (rmw),
    .i_single_byte   (single),
    .i_carry         (carry),
    .i_jump_done     (jdone),
`ifdef IRQ_EN
    .i_irq           (1'b0),
    .i_irq_mask      (1'b0),
    .o_hw_int        (o_hw_int),
`endif
    .o_state         (o_state),
    .o_sync          (o_sync),
    .o_pc_inc        (o_pc_inc),
    .o_addr_sel      (o_addr_sel),
    .o_we            (o_we),
    .o_ea_lo_ld      (o_ea_lo_ld),
    .o_ea_hi_ld      (o_ea_hi_ld),
    .o_idx_add       (o_idx_add),
    .o_fix_hi        (o_fix_hi),
    .o_s_dec         (o_s_dec),
    .o_s_inc         (o_s_inc),
    .o_commit        (o_commit),
    .o_jump_req      (o_jump_req),
    .o_jam           (o_jam)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] M_SYNC = 12'h800, M_PC  = 12'h400, M_WE   = 12'h200;
  localparam logic [11:0] M_ELO  = 12'h100, M_EHI = 12'h080, M_IDX  = 12'h040;
  localparam logic [11:0] M_FIX  = 12'h020, M_SDEC = 12'h010, M_SINC = 12'h008;
  localparam logic [11:0] M_COMMIT = 12'h004, M_JREQ = 12'h002, M_JAM = 12'h001;
  localparam logic [3:0]  P_RD = 4'b1000, P_LD = 4'b0100, P_ST = 4'b0010, P_RMW = 4'b0001;
  localparam logic [2:0]  A_PC = 3'd0, A_ZPG = 3'd1, A_EA = 3'd2, A_PTR = 3'd3;
  localparam logic [2:0]  A_STK = 3'd4, A_VEC = 3'd5;

  logic [20:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_exp = 0;

  logic [20:0] exp_v, act_v;
  string       nm_v;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm_v  = name_q.pop_front();
      act_v = {o_state, o_addr_sel, o_sync, o_pc_inc, o_we, o_ea_lo_ld, o_ea_hi_ld, o_idx_add,
               o_fix_hi, o_s_dec, o_s_inc, o_commit, o_jump_req, o_jam};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s: got state=%0d addr=%0d strobes=%b, expected state=%0d addr=%0d strobes=%b",
                 nm_v, act_v[20:15], act_v[14:12], act_v[11:0],
                 exp_v[20:15], exp_v[14:12], exp_v[11:0]);
      end
    end
  end

  task automatic set_op(input state_t s, input logic [3:0] pat, input logic sb);
    init = 6'(s);
    {rd, ld, st, rmw} = pat;
    single = sb;
  endtask

  // One bus cycle: drive inputs, queue the expected outputs, advance past the edge.
  task automatic cyc(input string nm, input logic r, input logic c, input logic j,
                     input state_t es, input logic [2:0] ea, input logic [11:0] em);
    rdy   = r;
    carry = c;
    jdone = j;
    exp_q.push_back({6'(es), ea, em});
    name_q.push_back(nm);
    n_exp++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LDA zpg: 3 cycles, no write
    set_op(T2_ZPG, P_RD, 1'b0);
    cyc("lda_zpg_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("lda_zpg_t1", 1, 0, 0, T1_DECODE, A_PC,  M_PC | M_ELO | M_COMMIT);
    cyc("lda_zpg_t2", 1, 0, 0, T2_ZPG,    A_ZPG, 12'h000);

    // LDA abs,X page cross: 5 cycles
    set_op(T2_ABSXY, P_LD, 1'b0);
    cyc("absx_c1_t0", 1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("absx_c1_t1", 1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    cyc("absx_c1_t2", 1, 1, 0, T2_ABSXY,  A_PC, M_PC | M_EHI | M_IDX);
    cyc("absx_c1_t3", 1, 0, 0, T3_FIX,    A_EA, M_FIX);
    cyc("absx_c1_dt", 1, 0, 0, DATA,      A_EA, 12'h000);

    // LDA abs,X no cross: 4 cycles
    cyc("absx_c0_t0", 1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("absx_c0_t1", 1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    cyc("absx_c0_t2", 1, 0, 0, T2_ABSXY,  A_PC, M_PC | M_EHI | M_IDX);
    cyc("absx_c0_dt", 1, 0, 0, DATA,      A_EA, 12'h000);

    // INC zpg: writes only in the two RMW cycles
    set_op(T2_ZPG, P_RMW, 1'b0);
    cyc("inc_t0",   1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("inc_t1",   1, 0, 0, T1_DECODE, A_PC,  M_PC | M_ELO | M_COMMIT);
    cyc("inc_t2",   1, 0, 0, T2_ZPG,    A_ZPG, 12'h000);
    cyc("inc_rmw1", 1, 0, 0, T_RMW1,    A_ZPG, M_WE);
    cyc("inc_rmw2", 1, 0, 0, T_RMW2,    A_ZPG, M_WE);

    // STA abs,Y always fixes; write ignores rdy
    set_op(T2_ABSXY, P_ST, 1'b0);
    cyc("sta_t0", 1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("sta_t1", 1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    cyc("sta_t2", 1, 0, 0, T2_ABSXY,  A_PC, M_PC | M_EHI | M_IDX);
    cyc("sta_t3", 1, 0, 0, T3_FIX,    A_EA, M_FIX);
    cyc("sta_dt", 0, 0, 0, DATA,      A_EA, M_WE);

    // Branch, stall in fetch, then taken with cross and stalled fix
    set_op(T2_BRANCH, P_RD, 1'b0);
    cyc("br_t0_stall", 0, 0, 0, T0_FETCH,  A_PC, M_SYNC);
    cyc("br_t0",       1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("br_t1",       1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    cyc("br_t2",       1, 1, 0, T2_BRANCH, A_PC, 12'h000);
    cyc("br_fix_st1",  0, 0, 0, T3_BRFIX,  A_PC, 12'h000);
    cyc("br_fix_st2",  0, 0, 0, T3_BRFIX,  A_PC, 12'h000);
    cyc("br_fix",      1, 0, 0, T3_BRFIX,  A_PC, M_FIX);
    cyc("br_nc_t0",    1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("br_nc_t1",    1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    cyc("br_nc_t2",    1, 0, 0, T2_BRANCH, A_PC, 12'h000);

    // BRK: pushes proceed with rdy low
    set_op(T2_BRK, P_RD, 1'b1);
    cyc("brk_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("brk_t1", 1, 0, 0, T1_DECODE, A_PC,  M_ELO | M_COMMIT);
    cyc("brk_t2", 0, 0, 0, T2_BRK,    A_STK, M_WE | M_SDEC);
    cyc("brk_t3", 0, 0, 0, T3_BRK,    A_STK, M_WE | M_SDEC);
    cyc("brk_t4", 0, 0, 0, T4_BRK,    A_STK, M_WE | M_SDEC);
    cyc("brk_t5", 1, 0, 0, T5_VEC,    A_VEC, M_ELO);
    cyc("brk_t6", 1, 0, 0, T6_VEC,    A_VEC, M_EHI);

    // PHA then PLA
    set_op(T2_STACK, P_ST, 1'b1);
    cyc("pha_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("pha_t1", 1, 0, 0, T1_DECODE, A_PC,  M_ELO | M_COMMIT);
    cyc("pha_t2", 1, 0, 0, T2_STACK,  A_STK, M_WE | M_SDEC);
    set_op(T2_STACK, P_LD, 1'b1);
    cyc("pla_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("pla_t1", 1, 0, 0, T1_DECODE, A_PC,  M_ELO | M_COMMIT);
    cyc("pla_t2", 1, 0, 0, T2_STACK,  A_STK, M_SINC);
    cyc("pla_t3", 1, 0, 0, T3_PULL,   A_STK, 12'h000);

    // (zp,X), (zp),Y without cross, zp,X
    set_op(T2_XIND, P_RD, 1'b0);
    cyc("xind_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("xind_t1", 1, 0, 0, T1_DECODE, A_PC,  M_PC | M_ELO | M_COMMIT);
    cyc("xind_t2", 1, 0, 0, T2_XIND,   A_ZPG, M_IDX);
    cyc("xind_t3", 1, 0, 0, T3_PTRLO,  A_PTR, M_ELO);
    cyc("xind_t4", 1, 0, 0, T4_PTRHI,  A_PTR, M_EHI);
    cyc("xind_dt", 1, 0, 0, DATA,      A_EA,  12'h000);
    set_op(T2_INDY, P_RD, 1'b0);
    cyc("indy_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("indy_t1", 1, 0, 0, T1_DECODE, A_PC,  M_PC | M_ELO | M_COMMIT);
    cyc("indy_t2", 1, 0, 0, T2_INDY,   A_PTR, M_ELO);
    cyc("indy_t3", 1, 0, 0, T3_PTRHI,  A_PTR, M_EHI | M_IDX);
    cyc("indy_dt", 1, 0, 0, DATA,      A_EA,  12'h000);
    set_op(T2_ZPGXY, P_RD, 1'b0);
    cyc("zpx_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("zpx_t1", 1, 0, 0, T1_DECODE, A_PC,  M_PC | M_ELO | M_COMMIT);
    cyc("zpx_t2", 1, 0, 0, T2_ZPGXY,  A_ZPG, M_IDX);
    cyc("zpx_dt", 1, 0, 0, DATA,      A_ZPG, 12'h000);

    // Jump completing on the third cycle
    set_op(T2_JUMP, P_RD, 1'b0);
    cyc("jmp_t0", 1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("jmp_t1", 1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    cyc("jmp_w1", 1, 0, 0, T2_JUMP,   A_PC, M_JREQ);
    cyc("jmp_w2", 1, 0, 0, T2_JUMP,   A_PC, M_JREQ);
    cyc("jmp_dn", 1, 0, 1, T2_JUMP,   A_PC, M_JREQ);

    // Jump timeout after 8 waiting cycles, then reset recovery
    cyc("jto_t0", 1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("jto_t1", 1, 0, 0, T1_DECODE, A_PC, M_PC | M_ELO | M_COMMIT);
    for (int i = 0; i < 8; i++) cyc("jto_wait", 1, 0, 0, T2_JUMP, A_PC, M_JREQ);
    cyc("jto_jam1", 1, 0, 1, T_JAM, A_PC, M_JAM);
    cyc("jto_jam2", 1, 0, 0, T_JAM, A_PC, M_JAM);
    rst = 1'b1;
    cyc("jto_rst", 1, 0, 0, T_JAM, A_PC, M_JAM);
    rst = 1'b0;

    // Decoder-requested jam and unknown entry state
    set_op(T_JAM, P_RD, 1'b1);
    cyc("jam_t0",  1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("jam_t1",  1, 0, 0, T1_DECODE, A_PC, M_ELO | M_COMMIT);
    cyc("jam_h1",  1, 0, 0, T_JAM,     A_PC, M_JAM);
    cyc("jam_h2",  0, 0, 0, T_JAM,     A_PC, M_JAM);
    rst = 1'b1;
    cyc("jam_rst", 1, 0, 0, T_JAM,     A_PC, M_JAM);
    rst = 1'b0;
    set_op(DATA, P_RD, 1'b1);
    cyc("unk_t0",  1, 0, 0, T0_FETCH,  A_PC, M_SYNC | M_PC);
    cyc("unk_t1",  1, 0, 0, T1_DECODE, A_PC, M_ELO | M_COMMIT);
    cyc("unk_jam", 1, 0, 0, T_JAM,     A_PC, M_JAM);
    rst = 1'b1;
    cyc("unk_rst", 1, 0, 0, T_JAM,     A_PC, M_JAM);
    rst = 1'b0;

    // Reset during an RMW write abandons the instruction
    set_op(T2_ZPG, P_RMW, 1'b0);
    cyc("rrst_t0", 1, 0, 0, T0_FETCH,  A_PC,  M_SYNC | M_PC);
    cyc("rrst_t1", 1, 0, 0, T1_DECODE, A_PC,  M_PC | M_ELO | M_COMMIT);
    cyc("rrst_t2", 1, 0, 0, T2_ZPG,    A_ZPG, 12'h000);
    rst = 1'b1;
    cyc("rrst_rmw1", 1, 0, 0, T_RMW1,  A_ZPG, M_WE);
    rst = 1'b0;
    cyc("rrst_after", 0, 0, 0, T0_FETCH, A_PC, M_SYNC);

    @(negedge clk);
    if (o_state !== 6'(T0_FETCH) || o_sync !== 1'b1 || o_we !== 1'b0 || o_pc_inc !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_hold: got state=%0d sync=%b we=%b pc_inc=%b, expected %0d 1 0 0",
               o_state, o_sync, o_we, o_pc_inc, T0_FETCH);
    end
    if (n_cmp != n_exp) begin
      n_bad++;
      $display("FAIL vector_count: got %0d compared, expected %0d", n_cmp, n_exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d mismatches", n_bad);
    end
    $finish;
  end

endmodule
